// File: rtl/eth_crc_pkg.sv
// Shared constants, FSM state type and the per-byte reflected CRC-32 update
// for the Ethernet FCS engine.
package eth_crc_pkg;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'h2144DF1C;

   typedef enum logic {
      ST_IDLE,
      ST_IN_FRAME
   } fcs_state_e;

   // Bytes enter LSB first, so the shift register runs right with the bit-reversed polynomial.
   function automatic logic [31:0] crcByteUpdate(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] polyRefl;
      logic [31:0] acc;
      for (int i = 0; i < 32; i++) begin
         polyRefl[i] = CRC_POLY[31-i];
      end
      acc = crc ^ {24'h000000, data};
      for (int b = 0; b < 8; b++) begin
         acc = acc[0] ? ((acc >> 1) ^ polyRefl) : (acc >> 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/eth_fcs_engine.sv
// Streaming IEEE 802.3 CRC-32 engine: folds DATA_BYTES lanes per beat, reports
// running and final FCS, residue check, protocol errors and frame/error counters.
module eth_fcs_engine
   import eth_crc_pkg::*;
#(
   parameter int DATA_BYTES = 1,
   parameter int CNT_W      = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sop,
   input  logic                    in_last,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [DATA_BYTES-1:0]   in_keep,
   output logic [31:0]             crc_run,
   output logic [31:0]             crc_out,
   output logic                    crc_valid,
   output logic                    crc_ok,
   output logic                    proto_err,
   output logic [CNT_W-1:0]        frame_cnt,
   output logic [CNT_W-1:0]        err_cnt
);

   generate
      if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4 || DATA_BYTES == 8)) begin : gBadWidth
         $error("eth_fcs_engine: DATA_BYTES must be 1, 2, 4 or 8");
      end
   endgenerate

   fcs_state_e             state_q, state_d;
   logic [31:0]            crc_q, crc_d;
   logic [31:0]            crcRun_q, crcRun_d;
   logic [31:0]            crcOut_q, crcOut_d;
   logic                   crcValid_q, crcValid_d;
   logic                   crcOk_q, crcOk_d;
   logic                   protoErr_q, protoErr_d;
   logic [CNT_W-1:0]       frameCnt_q, frameCnt_d;
   logic [CNT_W-1:0]       errCnt_q, errCnt_d;

   logic [DATA_BYTES-1:0]  laneEn;
   logic                   keepOn;
   logic                   keepGap;
   logic [31:0]            folded;
   logic [31:0]            crcFinal;
   logic                   accept;

   // Only the contiguous run of enabled lanes starting at lane 0 is folded on a last beat.
   always_comb begin
      laneEn = '1;
      keepOn = 1'b1;
      if (in_last) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            keepOn    = keepOn & in_keep[i];
            laneEn[i] = keepOn;
         end
      end
      keepGap = in_last && (in_keep != laneEn);
   end

   always_comb begin
      folded = in_sop ? CRC_INIT : crc_q;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (laneEn[i]) begin
            folded = crcByteUpdate(folded, in_data[8*i +: 8]);
         end
      end
      crcFinal = folded ^ CRC_XOROUT;
   end

   assign accept = in_valid && (in_sop || (state_q == ST_IN_FRAME));

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      crcRun_d   = crcRun_q;
      crcOut_d   = crcOut_q;
      crcValid_d = 1'b0;
      crcOk_d    = crcOk_q;
      protoErr_d = 1'b0;
      frameCnt_d = frameCnt_q;
      errCnt_d   = errCnt_q;
      if (in_valid) begin
         protoErr_d = (in_sop && (state_q == ST_IN_FRAME))
                   || (!in_sop && (state_q == ST_IDLE))
                   || (accept && keepGap);
      end
      if (accept) begin
         crc_d    = folded;
         crcRun_d = crcFinal;
         state_d  = in_last ? ST_IDLE : ST_IN_FRAME;
         if (in_last) begin
            crcOut_d   = crcFinal;
            crcOk_d    = (crcFinal == CRC_RESIDUE);
            crcValid_d = 1'b1;
            frameCnt_d = frameCnt_q + CNT_W'(1);
            if (crcFinal != CRC_RESIDUE) begin
               errCnt_d = errCnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         crc_q      <= CRC_INIT;
         crcRun_q   <= '0;
         crcOut_q   <= '0;
         crcValid_q <= 1'b0;
         crcOk_q    <= 1'b0;
         protoErr_q <= 1'b0;
         frameCnt_q <= '0;
         errCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         crcRun_q   <= crcRun_d;
         crcOut_q   <= crcOut_d;
         crcValid_q <= crcValid_d;
         crcOk_q    <= crcOk_d;
         protoErr_q <= protoErr_d;
         frameCnt_q <= frameCnt_d;
         errCnt_q   <= errCnt_d;
      end
   end

   assign crc_run   = crcRun_q;
   assign crc_out   = crcOut_q;
   assign crc_valid = crcValid_q;
   assign crc_ok    = crcOk_q;
   assign proto_err = protoErr_q;
   assign frame_cnt = frameCnt_q;
   assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_eth_fcs_engine.sv
// Directed self-checking bench: three engine instances (1, 4 and 8 byte lanes)
// driven with known CRC-32 vectors.
module tb_eth_fcs_engine;

   logic clk = 1'b0;
   logic rst;

   logic        v1, sop1, last1;
   logic [7:0]  d1;
   logic [0:0]  k1;
   logic        v4, sop4, last4;
   logic [31:0] d4;
   logic [3:0]  k4;
   logic        v8, sop8, last8;
   logic [63:0] d8;
   logic [7:0]  k8;

   logic [31:0] crcRun1, crcOut1, crcRun4, crcOut4, crcRun8, crcOut8;
   logic        crcValid1, crcOk1, protoErr1;
   logic        crcValid4, crcOk4, protoErr4;
   logic        crcValid8, crcOk8, protoErr8;
   logic [15:0] frameCnt1, errCnt1, frameCnt4, errCnt4;
   logic [3:0]  frameCnt8, errCnt8;

   int testsRun    = 0;
   int testsFailed = 0;
   logic [7:0] frameBytes[$];

   always #5 clk = ~clk;

   eth_fcs_engine #(.DATA_BYTES(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_sop(sop1), .in_last(last1),
      .in_data(d1), .in_keep(k1), .crc_run(crcRun1), .crc_out(crcOut1),
      .crc_valid(crcValid1), .crc_ok(crcOk1), .proto_err(protoErr1),
      .frame_cnt(frameCnt1), .err_cnt(errCnt1));

   eth_fcs_engine #(.DATA_BYTES(4), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_sop(sop4), .in_last(last4),
      .in_data(d4), .in_keep(k4), .crc_run(crcRun4), .crc_out(crcOut4),
      .crc_valid(crcValid4), .crc_ok(crcOk4), .proto_err(protoErr4),
      .frame_cnt(frameCnt4), .err_cnt(errCnt4));

   eth_fcs_engine #(.DATA_BYTES(8), .CNT_W(4)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_sop(sop8), .in_last(last8),
      .in_data(d8), .in_keep(k8), .crc_run(crcRun8), .crc_out(crcOut8),
      .crc_valid(crcValid8), .crc_ok(crcOk8), .proto_err(protoErr8),
      .frame_cnt(frameCnt8), .err_cnt(errCnt8));

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One beat to the selected instance; returns #1 after the sampling edge.
   task automatic applyStimulus(input int lanes, input bit sop, input bit last,
                                input logic [63:0] data, input logic [7:0] keep);
      @(negedge clk);
      case (lanes)
         1:       begin v1 = 1'b1; sop1 = sop; last1 = last; d1 = data[7:0];  k1 = keep[0:0]; end
         4:       begin v4 = 1'b1; sop4 = sop; last4 = last; d4 = data[31:0]; k4 = keep[3:0]; end
         default: begin v8 = 1'b1; sop8 = sop; last8 = last; d8 = data;       k8 = keep;      end
      endcase
      @(posedge clk);
      #1;
      v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
   endtask

   task automatic idleCycle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic loadString(input string s);
      frameBytes.delete();
      for (int i = 0; i < s.len(); i++) frameBytes.push_back(s[i]);
   endtask

   task automatic appendCheckFcs();
      frameBytes.push_back(8'h26);
      frameBytes.push_back(8'h39);
      frameBytes.push_back(8'hF4);
      frameBytes.push_back(8'hCB);
   endtask

   task automatic sendFrame(input int lanes);
      int nb;
      int beats;
      logic [63:0] data;
      logic [7:0]  keep;
      nb    = frameBytes.size();
      beats = (nb + lanes - 1) / lanes;
      for (int b = 0; b < beats; b++) begin
         data = '0;
         keep = '0;
         for (int l = 0; l < lanes; l++) begin
            if (b * lanes + l < nb) begin
               data[8*l +: 8] = frameBytes[b * lanes + l];
               keep[l]        = 1'b1;
            end
         end
         applyStimulus(lanes, b == 0, b == beats - 1, data, keep);
      end
   endtask

   initial begin
      rst = 1'b1;
      v1 = 0; sop1 = 0; last1 = 0; d1 = '0; k1 = '0;
      v4 = 0; sop4 = 0; last4 = 0; d4 = '0; k4 = '0;
      v8 = 0; sop8 = 0; last8 = 0; d8 = '0; k8 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst crc_run",   crcRun1, 32'h0);
      checkOutput("rst crc_out",   crcOut1, 32'h0);
      checkOutput("rst crc_valid", 32'(crcValid1), 32'h0);
      checkOutput("rst crc_ok",    32'(crcOk8), 32'h0);
      checkOutput("rst proto_err", 32'(protoErr4), 32'h0);
      checkOutput("rst frame_cnt", 32'(frameCnt1), 32'h0);
      checkOutput("rst err_cnt",   32'(errCnt8), 32'h0);

      // Standard check value, no FCS appended
      loadString("123456789");
      sendFrame(1);
      checkOutput("w1 crc_out",   crcOut1, 32'hCBF43926);
      checkOutput("w1 crc_run",   crcRun1, 32'hCBF43926);
      checkOutput("w1 crc_valid", 32'(crcValid1), 32'h1);
      checkOutput("w1 crc_ok",    32'(crcOk1), 32'h0);
      checkOutput("w1 frame_cnt", 32'(frameCnt1), 32'h1);
      checkOutput("w1 err_cnt",   32'(errCnt1), 32'h1);
      idleCycle();
      checkOutput("w1 valid drop", 32'(crcValid1), 32'h0);
      checkOutput("w1 out hold",  crcOut1, 32'hCBF43926);

      // "abc" with an idle gap inside the frame
      applyStimulus(1, 1, 0, 64'h61, 8'h1);
      checkOutput("gap run a",   crcRun1, 32'hE8B7BE43);
      checkOutput("gap valid a", 32'(crcValid1), 32'h0);
      idleCycle();
      checkOutput("gap run hold", crcRun1, 32'hE8B7BE43);
      applyStimulus(1, 0, 0, 64'h62, 8'h1);
      applyStimulus(1, 0, 1, 64'h63, 8'h1);
      checkOutput("gap crc_out",   crcOut1, 32'h352441C2);
      checkOutput("gap crc_valid", 32'(crcValid1), 32'h1);
      checkOutput("gap frame_cnt", 32'(frameCnt1), 32'h2);

      // Protocol errors: no-sop beat in idle, then sop restarting a frame
      applyReset();
      applyStimulus(1, 0, 0, 64'h78, 8'h1);
      checkOutput("pe idle beat",  32'(protoErr1), 32'h1);
      checkOutput("pe idle run",   crcRun1, 32'h0);
      applyStimulus(1, 1, 0, 64'h7A, 8'h1);
      checkOutput("pe clean sop",  32'(protoErr1), 32'h0);
      applyStimulus(1, 1, 0, 64'h61, 8'h1);
      checkOutput("pe resop",      32'(protoErr1), 32'h1);
      checkOutput("pe resop run",  crcRun1, 32'hE8B7BE43);
      applyStimulus(1, 0, 0, 64'h62, 8'h1);
      applyStimulus(1, 0, 1, 64'h63, 8'h1);
      checkOutput("pe crc_out",    crcOut1, 32'h352441C2);
      checkOutput("pe last clean", 32'(protoErr1), 32'h0);
      checkOutput("pe frame_cnt",  32'(frameCnt1), 32'h1);

      // Reset mid-frame, concurrent with a last beat
      applyReset();
      applyStimulus(1, 1, 0, 64'h31, 8'h1);
      checkOutput("mr run 1", crcRun1, 32'h83DCEFB7);
      applyStimulus(1, 0, 0, 64'h32, 8'h1);
      @(negedge clk);
      rst = 1'b1; v1 = 1'b1; sop1 = 1'b0; last1 = 1'b1; d1 = 8'h33; k1 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; v1 = 1'b0;
      checkOutput("mr crc_valid", 32'(crcValid1), 32'h0);
      checkOutput("mr frame_cnt", 32'(frameCnt1), 32'h0);
      checkOutput("mr crc_run",   crcRun1, 32'h0);
      loadString("123456789");
      sendFrame(1);
      checkOutput("mr fresh crc", crcOut1, 32'hCBF43926);
      checkOutput("mr fresh cnt", 32'(frameCnt1), 32'h1);

      // Four lanes: data plus FCS, last keep=0001
      loadString("123456789");
      appendCheckFcs();
      sendFrame(4);
      checkOutput("w4 crc_out",   crcOut4, 32'h2144DF1C);
      checkOutput("w4 crc_ok",    32'(crcOk4), 32'h1);
      checkOutput("w4 crc_valid", 32'(crcValid4), 32'h1);
      checkOutput("w4 err_cnt",   32'(errCnt4), 32'h0);
      applyStimulus(4, 1, 1, 64'h64636261, 8'b1001);
      checkOutput("w4 gap keep crc",   crcOut4, 32'hE8B7BE43);
      checkOutput("w4 gap keep proto", 32'(protoErr4), 32'h1);
      checkOutput("w4 gap keep valid", 32'(crcValid4), 32'h1);
      applyStimulus(4, 1, 1, 64'h64636261, 8'b0000);
      checkOutput("w4 keep0 crc",   crcOut4, 32'h0);
      checkOutput("w4 keep0 proto", 32'(protoErr4), 32'h0);
      applyStimulus(4, 1, 1, 64'h64636261, 8'b0111);
      checkOutput("w4 keep3 crc",   crcOut4, 32'h352441C2);
      checkOutput("w4 frame_cnt",   32'(frameCnt4), 32'h4);
      checkOutput("w4 err_cnt end", 32'(errCnt4), 32'h3);

      // Eight lanes: good frame then corrupted frame, back to back
      applyReset();
      loadString("123456789");
      appendCheckFcs();
      sendFrame(8);
      checkOutput("w8 good ok",    32'(crcOk8), 32'h1);
      checkOutput("w8 good valid", 32'(crcValid8), 32'h1);
      checkOutput("w8 good crc",   crcOut8, 32'h2144DF1C);
      frameBytes[0] = 8'h30;
      sendFrame(8);
      checkOutput("w8 bad ok",     32'(crcOk8), 32'h0);
      checkOutput("w8 bad valid",  32'(crcValid8), 32'h1);
      checkOutput("w8 err_cnt",    32'(errCnt8), 32'h1);
      checkOutput("w8 frame_cnt",  32'(frameCnt8), 32'h2);

      // Four-bit counter wrap after 17 good frames
      applyReset();
      for (int f = 0; f < 17; f++) begin
         loadString("123456789");
         appendCheckFcs();
         sendFrame(8);
      end
      checkOutput("wrap frame_cnt", 32'(frameCnt8), 32'h1);
      checkOutput("wrap err_cnt",   32'(errCnt8), 32'h0);
      checkOutput("wrap crc_ok",    32'(crcOk8), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
